// File: rtl/sm4_key_expand_if.sv
// Key-load and round-key read bus between the key register file / cipher core and
// the SM4 key-schedule engine.
interface sm4_key_expand_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [4:0]   rk_index;
    logic         rk_decrypt;
    logic [31:0]  rk_out;

    modport master (
        output key_in, key_valid, rk_index, rk_decrypt,
        input  key_ready, busy, done, rk_valid, rk_out
    );

    modport slave (
        input  key_in, key_valid, rk_index, rk_decrypt,
        output key_ready, busy, done, rk_valid, rk_out
    );
endinterface

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per clock into a 32x32 buffer,
// read back in encrypt or decrypt order through a registered indexed port.
module sm4_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the most significant byte of the table.
    always_comb begin
        o_out = SBOX_TABLE[11'd2047 - {i_in, 3'b000} -: 8];
    end
endmodule

module sm4_key_expand (
    input  logic              clk,
    input  logic              rst,
    sm4_key_expand_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [31:0] r_rk_mem [32];

    logic        r_key_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_rk_valid;
    logic [31:0] r_rk_out;

    logic        w_accept;
    logic [7:0]  w_ck_base;
    logic [31:0] w_ck;
    logic [31:0] w_x;
    logic [31:0] w_b;
    logic [31:0] w_rk;
    logic [4:0]  w_rd_addr;

    assign w_accept  = bus.key_valid & r_key_ready;
    assign w_ck_base = {3'd0, r_cnt} * 8'd28;
    assign w_ck      = {w_ck_base, w_ck_base + 8'd7, w_ck_base + 8'd14, w_ck_base + 8'd21};
    assign w_x       = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;
    assign w_rk      = r_k0 ^ w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
    assign w_rd_addr = bus.rk_decrypt ? (5'd31 - bus.rk_index) : bus.rk_index;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            sm4_sbox u_sbox (
                .i_in  (w_x[8*g +: 8]),
                .o_out (w_b[8*g +: 8])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a key is accepted in IDLE or READY, ignored while expanding.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_EXPAND;
                else          w_state_next = ST_IDLE;
            end
            ST_EXPAND: begin
                if (r_cnt == 5'd31) w_state_next = ST_READY;
                else                w_state_next = ST_EXPAND;
            end
            ST_READY: begin
                if (w_accept) w_state_next = ST_EXPAND;
                else          w_state_next = ST_READY;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Key shift register and round counter; the counter saturates at 31.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
            r_k0  <= 32'd0;
            r_k1  <= 32'd0;
            r_k2  <= 32'd0;
            r_k3  <= 32'd0;
        end else if (w_accept) begin
            r_cnt <= 5'd0;
            r_k0  <= bus.key_in[127:96] ^ FK0;
            r_k1  <= bus.key_in[95:64]  ^ FK1;
            r_k2  <= bus.key_in[63:32]  ^ FK2;
            r_k3  <= bus.key_in[31:0]   ^ FK3;
        end else if (r_state == ST_EXPAND) begin
            r_cnt <= (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
            r_k0  <= r_k1;
            r_k1  <= r_k2;
            r_k2  <= r_k3;
            r_k3  <= w_rk;
        end else begin
            r_cnt <= r_cnt;
            r_k0  <= r_k0;
            r_k1  <= r_k1;
            r_k2  <= r_k2;
            r_k3  <= r_k3;
        end
    end

    // Round-key buffer; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_EXPAND)) begin
            r_rk_mem[r_cnt] <= w_rk;
        end
    end

    // Registered status and read port; a same-cycle rekey already blanks the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_rk_out    <= 32'd0;
        end else begin
            r_key_ready <= (w_state_next != ST_EXPAND);
            r_busy      <= (w_state_next == ST_EXPAND);
            r_done      <= (r_state == ST_EXPAND) && (r_cnt == 5'd31);
            r_rk_valid  <= (w_state_next == ST_READY);
            r_rk_out    <= (r_rk_valid && !w_accept) ? r_rk_mem[w_rd_addr] : 32'd0;
        end
    end

    assign bus.key_ready = r_key_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rk_valid  = r_rk_valid;
    assign bus.rk_out    = r_rk_out;
endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand: known-answer reads, order sweeps against an
// independent key-schedule model, and the multi-cycle handshake corner cases.
module tb_sm4_key_expand;
    logic clk = 1'b0;
    logic rst;
    sm4_key_expand_if bus ();

    sm4_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KEY_ALT = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] KEY_B   = 128'hDEADBEEFCAFEF00D0F1E2D3C4B5A6978;

    localparam logic [7:0] SB [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    typedef struct {
        string       name;
        logic        dec;
        logic [4:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t     vecs [6];
    logic [31:0] gold_rk [32];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compute_gold(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] t, s, ck;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
            s = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
            k[i+4] = k[i] ^ s ^ ((s << 13) | (s >> 19)) ^ ((s << 23) | (s >> 9));
            gold_rk[i] = k[i+4];
        end
    endtask

    // Drive a one-cycle key pulse; returns in the cycle after the sampling edge.
    task automatic apply_key(input logic [127:0] k);
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus.done !== 1'b1 && lat < 80) begin
            step();
            lat++;
        end
    endtask

    task automatic read_rk(input logic dec, input logic [4:0] idx, output logic [31:0] v);
        bus.rk_decrypt = dec;
        bus.rk_index   = idx;
        step();
        v = bus.rk_out;
    endtask

    task automatic sweep(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            for (int d = 0; d < 2; d++) begin
                read_rk(d[0], 5'(i), v);
                check($sformatf("%s_d%0d_i%0d", tag, d, i), v, d ? gold_rk[31-i] : gold_rk[i]);
            end
        end
    endtask

    initial begin
        int          lat;
        int          snap;
        logic [31:0] v;

        vecs[0] = '{"enc_rk0",  1'b0, 5'd0,  32'hF12186F9};
        vecs[1] = '{"enc_rk1",  1'b0, 5'd1,  32'h41662B61};
        vecs[2] = '{"enc_rk31", 1'b0, 5'd31, 32'h9124A012};
        vecs[3] = '{"dec_i0",   1'b1, 5'd0,  32'h9124A012};
        vecs[4] = '{"dec_i31",  1'b1, 5'd31, 32'hF12186F9};
        vecs[5] = '{"dec_i30",  1'b1, 5'd30, 32'h41662B61};

        rst            = 1'b1;
        bus.key_in     = 128'd0;
        bus.key_valid  = 1'b0;
        bus.rk_index   = 5'd0;
        bus.rk_decrypt = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_key_ready", 32'(bus.key_ready), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_rk_valid",  32'(bus.rk_valid),  32'd0);
        check("rst_rk_out",    bus.rk_out,         32'd0);

        // Standard vector
        compute_gold(KEY_STD);
        done_cnt = 0;
        apply_key(KEY_STD);
        check("exp_busy",      32'(bus.busy),      32'd1);
        check("exp_key_ready", 32'(bus.key_ready), 32'd0);
        check("exp_rk_valid",  32'(bus.rk_valid),  32'd0);
        wait_done(1, lat);
        check("std_latency",   32'(lat),           32'd33);
        check("std_rk_valid",  32'(bus.rk_valid),  32'd1);
        check("std_key_ready", 32'(bus.key_ready), 32'd1);
        step();
        check("std_done_pulse", 32'(bus.done),     32'd0);
        for (int i = 0; i < 6; i++) begin
            read_rk(vecs[i].dec, vecs[i].idx, v);
            check(vecs[i].name, v, vecs[i].exp);
        end
        sweep("std");

        // Busy blocking: a second key at T+5 must be ignored
        done_cnt = 0;
        apply_key(KEY_STD);
        repeat (4) step();
        check("blk_key_ready", 32'(bus.key_ready), 32'd0);
        apply_key(KEY_ALT);
        wait_done(6, lat);
        check("blk_latency", 32'(lat), 32'd33);
        repeat (40) step();
        check("blk_done_count", 32'(done_cnt), 32'd1);
        sweep("blk");

        // Rekey from READY with a simultaneous read
        compute_gold(128'd0);
        bus.rk_index   = 5'd0;
        bus.rk_decrypt = 1'b0;
        apply_key(128'd0);
        check("rekey_rk_valid", 32'(bus.rk_valid), 32'd0);
        check("rekey_rd_zero",  bus.rk_out,        32'd0);
        step();
        check("rekey_mid_zero", bus.rk_out,        32'd0);
        wait_done(2, lat);
        check("rekey_latency", 32'(lat), 32'd33);
        read_rk(1'b0, 5'd0, v);
        check("rekey_rk0", v, gold_rk[0]);
        sweep("zero");

        // Reset in the middle of an expansion
        apply_key(KEY_STD);
        repeat (9) step();
        snap = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_key_ready", 32'(bus.key_ready), 32'd1);
        check("mrst_rk_valid",  32'(bus.rk_valid),  32'd0);
        check("mrst_busy",      32'(bus.busy),      32'd0);
        check("mrst_done",      32'(bus.done),      32'd0);
        check("mrst_rk_out",    bus.rk_out,         32'd0);
        repeat (40) step();
        check("mrst_no_done",   32'(done_cnt),      32'(snap));
        check("mrst_still_inv", 32'(bus.rk_valid),  32'd0);
        compute_gold(KEY_ALT);
        apply_key(KEY_ALT);
        wait_done(1, lat);
        check("mrst_latency", 32'(lat), 32'd33);
        sweep("alt");

        // Back-to-back: key B presented in the first READY cycle after key A
        apply_key(KEY_STD);
        wait_done(1, lat);
        check("b2b_a_latency", 32'(lat), 32'd33);
        compute_gold(KEY_B);
        apply_key(KEY_B);
        check("b2b_rk_valid", 32'(bus.rk_valid), 32'd0);
        wait_done(1, lat);
        check("b2b_b_latency", 32'(lat), 32'd33);
        step();
        sweep("keyb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
